ltl_report_collector: RTL and testbench

- Sits directly downstream of each generated LTL automaton cluster and consumes its per-report-STE active_state outputs.
- Tags every cycle with at least one asserted report with the index of the symbol that caused it.
- Buffers tagged events in a FIFO and drains them to the monitor's host/CSR side over a valid/ready interface.
- Tracks dropped events and latches the first violation index for fast status readout.

---
 rtl/ltl_report_collector.sv | 145 ++++++++++++++
 tb/tb_ltl_report_collector.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ltl_report_collector.sv
// ltl_report_collector: tags report activity from an LTL automaton cluster with
// the symbol index that caused it, buffers the events in a small FIFO and
// drains them over a valid/ready interface. Tracks drops and the first event.
module ltl_report_collector #(
  parameter int unsigned NUM_REPORTS = 4,
  parameter int unsigned IDX_W       = 16,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned DROP_W      = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run,
  input  logic                         clear,
  input  logic [NUM_REPORTS-1:0]       reports,
  output logic                         ev_valid,
  input  logic                         ev_ready,
  output logic [IDX_W+NUM_REPORTS-1:0] ev_data,
  output logic [$clog2(DEPTH):0]       fifo_count,
  output logic                         overflow,
  output logic [DROP_W-1:0]            drop_count,
  output logic                         first_valid,
  output logic [IDX_W-1:0]             first_idx
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = IDX_W + NUM_REPORTS;

  logic [IDX_W-1:0]   sym_idx_q, sym_idx_d;
  logic               run_q, run_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [DROP_W-1:0]  drop_q, drop_d;
  logic               first_valid_q, first_valid_d;
  logic [IDX_W-1:0]   first_idx_q, first_idx_d;

  logic full_c;
  logic event_c;
  logic pop_c;
  logic push_c;

  // Head of the FIFO is presented directly; the slot under rd_ptr is stable
  // until it is popped, so ev_data holds while the consumer stalls.
  assign ev_valid    = (count_q != '0);
  assign ev_data     = ev_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_count  = count_q;
  assign overflow    = overflow_q;
  assign drop_count  = drop_q;
  assign first_valid = first_valid_q;
  assign first_idx   = first_idx_q;

  // Event qualification and FIFO handshake decisions for this cycle.
  always_comb begin
    full_c  = (count_q == CNT_W'(DEPTH));
    event_c = run_q && (|reports);
    pop_c   = ev_valid && ev_ready;
    push_c  = event_c && (!full_c || pop_c);
  end

  // Next-state for index tracking, FIFO storage and status; clear wins over all.
  always_comb begin
    sym_idx_d     = sym_idx_q;
    run_d         = run;
    idx_d         = idx_q;
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    overflow_d    = overflow_q;
    drop_d        = drop_q;
    first_valid_d = first_valid_q;
    first_idx_d   = first_idx_q;

    if (clear) begin
      sym_idx_d     = '0;
      run_d         = 1'b0;
      idx_d         = '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_d[i] = '0;
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      overflow_d    = 1'b0;
      drop_d        = '0;
      first_valid_d = 1'b0;
      first_idx_d   = '0;
    end else begin
      if (run) begin
        idx_d     = sym_idx_q;
        sym_idx_d = sym_idx_q + IDX_W'(1);
      end

      if (pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);

      if (push_c) begin
        mem_d[wr_ptr_q] = {idx_q, reports};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else if (event_c) begin
        overflow_d = 1'b1;
        if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
      end

      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

      if (event_c && !first_valid_q) begin
        first_valid_d = 1'b1;
        first_idx_d   = idx_q;
      end
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sym_idx_q     <= '0;
      run_q         <= 1'b0;
      idx_q         <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      drop_q        <= '0;
      first_valid_q <= 1'b0;
      first_idx_q   <= '0;
    end else begin
      sym_idx_q     <= sym_idx_d;
      run_q         <= run_d;
      idx_q         <= idx_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      drop_q        <= drop_d;
      first_valid_q <= first_valid_d;
      first_idx_q   <= first_idx_d;
    end
  end

endmodule

// File: tb/tb_ltl_report_collector.sv
// Testbench for ltl_report_collector: directed and random stimulus compared
// against a queue-based reference model of the collector.
module tb_ltl_report_collector;

  localparam int NR    = 4;
  localparam int IW    = 16;
  localparam int DEPTH = 8;
  localparam int DW    = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              run;
  logic              clear;
  logic [NR-1:0]     reports;
  logic              ev_valid;
  logic              ev_ready;
  logic [IW+NR-1:0]  ev_data;
  logic [3:0]        fifo_count;
  logic              overflow;
  logic [DW-1:0]     drop_count;
  logic              first_valid;
  logic [IW-1:0]     first_idx;

  ltl_report_collector #(.NUM_REPORTS(NR), .IDX_W(IW), .DEPTH(DEPTH), .DROP_W(DW)) dut (
    .clk(clk), .reset(reset), .run(run), .clear(clear), .reports(reports),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
    .fifo_count(fifo_count), .overflow(overflow), .drop_count(drop_count),
    .first_valid(first_valid), .first_idx(first_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: symbol counter as plain integer, FIFO as a queue.
  int              m_sym;
  bit              m_prev_run;
  int              m_prev_idx;
  logic [IW+NR-1:0] m_q[$];
  bit              m_ovf;
  int              m_drops;
  bit              m_fv;
  int              m_fi;

  task automatic model_reset();
    m_sym = 0; m_prev_run = 0; m_prev_idx = 0;
    m_q.delete(); m_ovf = 0; m_drops = 0; m_fv = 0; m_fi = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("ev_valid", 32'(ev_valid), 32'(m_q.size() > 0));
    chk("ev_data", 32'(ev_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
    chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("drop_count", 32'(drop_count), 32'(m_drops));
    chk("first_valid", 32'(first_valid), 32'(m_fv));
    chk("first_idx", 32'(first_idx), 32'(m_fi));
  endtask

  // Apply one cycle of inputs, advance the model, clock, then compare.
  task automatic step(input bit r, input logic [NR-1:0] rep, input bit rdy,
                      input bit clr, input bit do_check);
    bit had_head;
    run = r; reports = rep; ev_ready = rdy; clear = clr;
    if (clr) begin
      model_reset();
    end else begin
      had_head = (m_q.size() > 0);
      if (had_head && rdy) void'(m_q.pop_front());
      if (m_prev_run && (rep != '0)) begin
        if (!m_fv) begin m_fv = 1; m_fi = m_prev_idx; end
        if (m_q.size() < DEPTH) m_q.push_back({IW'(m_prev_idx), rep});
        else begin
          m_ovf = 1;
          if (m_drops < (1 << DW) - 1) m_drops++;
        end
      end
      m_prev_run = r;
      if (r) begin
        m_prev_idx = m_sym;
        m_sym = (m_sym + 1) % (1 << IW);
      end
    end
    @(posedge clk);
    #1;
    if (do_check) check_all();
  endtask

  initial begin
    run = 0; clear = 0; reports = '0; ev_ready = 0;
    reset = 1;
    model_reset();
    #12;
    check_all();
    reset = 0;
    #3;
    @(posedge clk); #1;

    // Single event on symbol 2.
    for (int i = 0; i < 7; i++)
      step(i < 5, (i == 3) ? 4'b0100 : 4'b0000, 1'b0, 1'b0, 1'b1);
    chk("t1_head", 32'(ev_data), 32'({16'd2, 4'b0100}));
    chk("t1_first_idx", 32'(first_idx), 32'd2);
    chk("t1_count", 32'(fifo_count), 32'd1);

    // Overflow: ten events with no consumer.
    step(1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 11; i++)
      step(i < 10, (i >= 1) ? 4'b0001 : 4'b0000, 1'b0, 1'b0, 1'b1);
    chk("t2_count", 32'(fifo_count), 32'd8);
    chk("t2_drops", 32'(drop_count), 32'd2);
    chk("t2_ovf", 32'(overflow), 32'd1);

    // Full FIFO: pop and push in the same cycle.
    step(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 4'b1010, 1'b1, 1'b0, 1'b1);
    chk("t3_count", 32'(fifo_count), 32'd8);
    chk("t3_drops", 32'(drop_count), 32'd2);

    // Drain everything.
    for (int i = 0; i < 10; i++) step(1'b0, 4'b0000, 1'b1, 1'b0, 1'b1);
    chk("t2_drained", 32'(fifo_count), 32'd0);

    // Reports ignored while run is low.
    step(1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 4'b1111, 1'b0, 1'b0, 1'b1);
    chk("t4_fv", 32'(first_valid), 32'd0);
    chk("t4_count", 32'(fifo_count), 32'd0);

    // Index wrap: events on symbols FFFF and 0000.
    step(1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 65538; i++)
      step(i < 65537, (i >= 65536) ? 4'b0001 : 4'b0000, 1'b0, 1'b0, i > 65530);
    chk("t5_head_ffff", 32'(ev_data), 32'({16'hFFFF, 4'b0001}));
    step(1'b0, 4'b0000, 1'b1, 1'b0, 1'b1);
    chk("t5_head_0000", 32'(ev_data), 32'({16'h0000, 4'b0001}));

    // Clear with three stored entries and a coincident event.
    step(1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 4'b0011, 1'b0, 1'b0, 1'b1);
    chk("t6_pre_count", 32'(fifo_count), 32'd3);
    step(1'b1, 4'b0110, 1'b0, 1'b1, 1'b1);
    chk("t6_count", 32'(fifo_count), 32'd0);
    chk("t6_fv", 32'(first_valid), 32'd0);
    step(1'b1, 4'b0000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 4'b1000, 1'b0, 1'b0, 1'b1);
    chk("t6_idx0", 32'(ev_data), 32'({16'd0, 4'b1000}));

    // Random traffic with occasional clears.
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 3) != 0), NR'($urandom_range(0, 3) == 0 ? 0 : $urandom),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 199) == 0), 1'b1);

    // Build up entries, then asynchronous reset mid-drain.
    for (int i = 0; i < 5; i++) step(1'b1, 4'b0101, 1'b0, 1'b0, 1'b1);
    step(1'b0, 4'b0000, 1'b1, 1'b0, 1'b1);
    chk("t7_pre_valid", 32'(ev_valid), 32'd1);
    #2;
    reset = 1;
    #1;
    chk("t7_async_valid", 32'(ev_valid), 32'd0);
    chk("t7_async_count", 32'(fifo_count), 32'd0);
    model_reset();
    run = 0; ev_ready = 0; reports = '0;
    #1;
    reset = 0;
    @(posedge clk); #1;
    check_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
